// File: rtl/l1_refill_arbiter.sv
// L1 refill arbiter: grants one of two cache requesters a 64-byte line burst.
// Optional REFILL_ARB_ROUND_ROBIN_EN alternates simultaneous grants.
module l1_refill_arbiter #(
    parameter int P_BEATS = 8
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iINST_REQ,
    output logic        oINST_LOCK,
    input  logic [1:0]  iINST_MMUMOD,
    input  logic [31:0] iINST_ADDR,
    output logic        oINST_VALID,
    input  logic        iDATA_REQ,
    output logic        oDATA_LOCK,
    input  logic [1:0]  iDATA_MMUMOD,
    input  logic [31:0] iDATA_ADDR,
    output logic        oDATA_VALID,
    output logic        oRD_PAGEFAULT,
    output logic [63:0] oRD_DATA,
    output logic [27:0] oRD_MMU_FLAGS,
    output logic        oMEM_REQ,
    input  logic        iMEM_LOCK,
    output logic [1:0]  oMEM_MMUMOD,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_VALID,
    input  logic        iMEM_PAGEFAULT,
    input  logic [63:0] iMEM_DATA,
    input  logic [27:0] iMEM_MMU_FLAGS
);

    localparam logic [3:0] LP_LAST = 4'(P_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GET,
        ST_DRAIN
    } state_t;

    state_t      b_state;
    logic        b_owner;
    logic [25:0] b_line;
    logic [1:0]  b_mode;
    logic [3:0]  b_issued;
    logic [3:0]  b_received;

    logic idle;
    logic prio_inst;
    logic inst_grant;
    logic data_grant;
    logic beat_fwd;
    logic mem_issue;
    logic burst_done;
    logic unused_addr;

    assign idle = (b_state == ST_IDLE);

`ifdef REFILL_ARB_ROUND_ROBIN_EN
    logic b_last_owner;

    // Remember the owner of the last finished burst so the other side wins ties
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            b_last_owner <= 1'b1;
        end else if (burst_done) begin
            b_last_owner <= b_owner;
        end
    end

    assign prio_inst = b_last_owner;
`else
    assign prio_inst = 1'b1;
`endif

    assign inst_grant = idle & iINST_REQ & (~iDATA_REQ | prio_inst);
    assign data_grant = idle & iDATA_REQ & ~(iINST_REQ & prio_inst);

    assign beat_fwd  = ((b_state == ST_REQ) || (b_state == ST_GET)) & iMEM_VALID;
    assign mem_issue = (b_state == ST_REQ) & ~iMEM_LOCK;

    assign burst_done =
        ((b_state == ST_GET) & iMEM_VALID & ~iMEM_PAGEFAULT & (b_received == LP_LAST)) |
        ((b_state == ST_DRAIN) & (b_received == b_issued));

    // Burst sequencing: accept, issue beats, collect responses, drain on fault
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            b_state    <= ST_IDLE;
            b_owner    <= 1'b0;
            b_line     <= '0;
            b_mode     <= '0;
            b_issued   <= '0;
            b_received <= '0;
        end else begin
            unique case (b_state)
                ST_IDLE: begin
                    if (inst_grant) begin
                        b_owner    <= 1'b0;
                        b_line     <= iINST_ADDR[31:6];
                        b_mode     <= iINST_MMUMOD;
                        b_issued   <= '0;
                        b_received <= '0;
                        b_state    <= ST_REQ;
                    end else if (data_grant) begin
                        b_owner    <= 1'b1;
                        b_line     <= iDATA_ADDR[31:6];
                        b_mode     <= iDATA_MMUMOD;
                        b_issued   <= '0;
                        b_received <= '0;
                        b_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_issue) begin
                        b_issued <= b_issued + 4'd1;
                    end
                    if (iMEM_VALID) begin
                        b_received <= b_received + 4'd1;
                    end
                    if (iMEM_VALID && iMEM_PAGEFAULT) begin
                        b_state <= ST_DRAIN;
                    end else if (mem_issue && (b_issued == LP_LAST)) begin
                        b_state <= ST_GET;
                    end
                end
                ST_GET: begin
                    if (iMEM_VALID) begin
                        b_received <= b_received + 4'd1;
                        if (iMEM_PAGEFAULT) begin
                            b_state <= ST_DRAIN;
                        end else if (b_received == LP_LAST) begin
                            b_state <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (b_received == b_issued) begin
                        b_state <= ST_IDLE;
                    end else if (iMEM_VALID) begin
                        b_received <= b_received + 4'd1;
                    end
                end
                default: begin
                    b_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oINST_LOCK = ~idle | data_grant;
    assign oDATA_LOCK = ~idle | inst_grant;

    assign oMEM_REQ    = mem_issue;
    assign oMEM_ADDR   = {b_line, b_issued[2:0], 3'b000};
    assign oMEM_MMUMOD = b_mode;

    assign oINST_VALID = beat_fwd & ~b_owner;
    assign oDATA_VALID = beat_fwd & b_owner;

    assign oRD_PAGEFAULT = iMEM_PAGEFAULT;
    assign oRD_DATA      = iMEM_DATA;
    assign oRD_MMU_FLAGS = iMEM_MMU_FLAGS;

    assign unused_addr = ^{iINST_ADDR[5:0], iDATA_ADDR[5:0]};

endmodule

// File: tb/tb_l1_refill_arbiter.sv
// Directed bench for l1_refill_arbiter.
// Arbitration expectations follow REFILL_ARB_ROUND_ROBIN_EN when defined.
module tb_l1_refill_arbiter;

`ifdef REFILL_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC;
    logic        iINST_REQ;
    logic        oINST_LOCK;
    logic [1:0]  iINST_MMUMOD;
    logic [31:0] iINST_ADDR;
    logic        oINST_VALID;
    logic        iDATA_REQ;
    logic        oDATA_LOCK;
    logic [1:0]  iDATA_MMUMOD;
    logic [31:0] iDATA_ADDR;
    logic        oDATA_VALID;
    logic        oRD_PAGEFAULT;
    logic [63:0] oRD_DATA;
    logic [27:0] oRD_MMU_FLAGS;
    logic        oMEM_REQ;
    logic        iMEM_LOCK;
    logic [1:0]  oMEM_MMUMOD;
    logic [31:0] oMEM_ADDR;
    logic        iMEM_VALID;
    logic        iMEM_PAGEFAULT;
    logic [63:0] iMEM_DATA;
    logic [27:0] iMEM_MMU_FLAGS;

    int n_chk = 0;
    int n_fail = 0;
    int nreq;
    int beat;

    l1_refill_arbiter #(.P_BEATS(8)) dut (
        .iCLOCK(iCLOCK),
        .iRESET_SYNC(iRESET_SYNC),
        .iINST_REQ(iINST_REQ),
        .oINST_LOCK(oINST_LOCK),
        .iINST_MMUMOD(iINST_MMUMOD),
        .iINST_ADDR(iINST_ADDR),
        .oINST_VALID(oINST_VALID),
        .iDATA_REQ(iDATA_REQ),
        .oDATA_LOCK(oDATA_LOCK),
        .iDATA_MMUMOD(iDATA_MMUMOD),
        .iDATA_ADDR(iDATA_ADDR),
        .oDATA_VALID(oDATA_VALID),
        .oRD_PAGEFAULT(oRD_PAGEFAULT),
        .oRD_DATA(oRD_DATA),
        .oRD_MMU_FLAGS(oRD_MMU_FLAGS),
        .oMEM_REQ(oMEM_REQ),
        .iMEM_LOCK(iMEM_LOCK),
        .oMEM_MMUMOD(oMEM_MMUMOD),
        .oMEM_ADDR(oMEM_ADDR),
        .iMEM_VALID(iMEM_VALID),
        .iMEM_PAGEFAULT(iMEM_PAGEFAULT),
        .iMEM_DATA(iMEM_DATA),
        .iMEM_MMU_FLAGS(iMEM_MMU_FLAGS)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    // Eight issue cycles with a response trailing each issue by one cycle,
    // then one GET cycle carrying the last response.
    task automatic burst(input bit own_data, input logic [31:0] base, input logic [1:0] mode);
        logic [31:0] line;
        line = base & 32'hFFFF_FFC0;
        for (int i = 0; i < 9; i++) begin
            iMEM_LOCK      = 1'b0;
            iMEM_VALID     = (i > 0);
            iMEM_PAGEFAULT = 1'b0;
            iMEM_DATA      = {32'hD000_0000 | 32'(i), base};
            iMEM_MMU_FLAGS = 28'(i * 3 + 1);
            #1;
            chk("mreq", 64'(oMEM_REQ), 64'(i < 8));
            if (i < 8) begin
                chk("maddr", 64'(oMEM_ADDR), 64'(line + 32'(i * 8)));
                chk("mmode", 64'(oMEM_MMUMOD), 64'(mode));
            end
            chk("ivalid", 64'(oINST_VALID), 64'((i > 0) && !own_data));
            chk("dvalid", 64'(oDATA_VALID), 64'((i > 0) && own_data));
            if (i > 0) begin
                chk("rdata", oRD_DATA, {32'hD000_0000 | 32'(i), base});
            end
            chk("ilock_busy", 64'(oINST_LOCK), 64'(1));
            chk("dlock_busy", 64'(oDATA_LOCK), 64'(1));
            step();
        end
        iMEM_VALID = 1'b0;
    endtask

    initial begin
        iRESET_SYNC    = 1'b1;
        iINST_REQ      = 1'b0;
        iINST_MMUMOD   = 2'd0;
        iINST_ADDR     = 32'h0;
        iDATA_REQ      = 1'b0;
        iDATA_MMUMOD   = 2'd0;
        iDATA_ADDR     = 32'h0;
        iMEM_LOCK      = 1'b0;
        iMEM_VALID     = 1'b1;
        iMEM_PAGEFAULT = 1'b1;
        iMEM_DATA      = 64'h0123_4567_89AB_CDEF;
        iMEM_MMU_FLAGS = 28'hABCDEF1;
        step();
        step();
        #1;
        chk("rst_mreq", 64'(oMEM_REQ), 64'(0));
        chk("rst_ivalid", 64'(oINST_VALID), 64'(0));
        chk("rst_dvalid", 64'(oDATA_VALID), 64'(0));
        chk("rst_rdata", oRD_DATA, 64'h0123_4567_89AB_CDEF);
        chk("rst_flags", 64'(oRD_MMU_FLAGS), 64'h0ABC_DEF1);
        chk("rst_pf", 64'(oRD_PAGEFAULT), 64'(1));
        chk("rst_ilock", 64'(oINST_LOCK), 64'(0));
        chk("rst_maddr", 64'(oMEM_ADDR), 64'(0));
        iRESET_SYNC    = 1'b0;
        iMEM_VALID     = 1'b0;
        iMEM_PAGEFAULT = 1'b0;
        step();

        // Single INST burst at 0x1234
        iINST_REQ    = 1'b1;
        iINST_ADDR   = 32'h0000_1234;
        iINST_MMUMOD = 2'd2;
        #1;
        chk("t1_ilock", 64'(oINST_LOCK), 64'(0));
        chk("t1_dlock", 64'(oDATA_LOCK), 64'(1));
        step();
        iINST_REQ = 1'b0;
        burst(1'b0, 32'h0000_1234, 2'd2);
        iMEM_VALID = 1'b1;
        #1;
        chk("t1_idle_ilock", 64'(oINST_LOCK), 64'(0));
        chk("t1_idle_ivalid", 64'(oINST_VALID), 64'(0));
        chk("t1_idle_mreq", 64'(oMEM_REQ), 64'(0));
        step();
        iMEM_VALID = 1'b0;

        // Simultaneous requests twice back-to-back, from reset
        iRESET_SYNC = 1'b1;
        step();
        iRESET_SYNC  = 1'b0;
        iINST_REQ    = 1'b1;
        iINST_ADDR   = 32'h0000_1000;
        iINST_MMUMOD = 2'd1;
        iDATA_REQ    = 1'b1;
        iDATA_ADDR   = 32'h0000_2000;
        iDATA_MMUMOD = 2'd3;
        #1;
        chk("t2a_ilock", 64'(oINST_LOCK), 64'(0));
        chk("t2a_dlock", 64'(oDATA_LOCK), 64'(1));
        step();
        burst(1'b0, 32'h0000_1000, 2'd1);
        #1;
        chk("t2b_ilock", 64'(oINST_LOCK), 64'(RR));
        chk("t2b_dlock", 64'(oDATA_LOCK), 64'(!RR));
        step();
        iINST_REQ = 1'b0;
        iDATA_REQ = 1'b0;
        if (RR) begin
            burst(1'b1, 32'h0000_2000, 2'd3);
        end else begin
            burst(1'b0, 32'h0000_1000, 2'd1);
        end

        // Memory lock held for three cycles at beat 2
        iINST_REQ    = 1'b1;
        iINST_ADDR   = 32'h0000_4000;
        iINST_MMUMOD = 2'd0;
        step();
        iINST_REQ = 1'b0;
        nreq = 0;
        beat = 0;
        for (int i = 0; i < 11; i++) begin
            iMEM_LOCK = (i >= 2 && i <= 4);
            #1;
            chk("t3_mreq", 64'(oMEM_REQ), 64'(!iMEM_LOCK));
            chk("t3_maddr", 64'(oMEM_ADDR), 64'(32'h4000 + 32'(beat * 8)));
            if (oMEM_REQ) nreq++;
            if (!iMEM_LOCK) beat++;
            step();
        end
        iMEM_LOCK = 1'b0;
        for (int j = 0; j < 8; j++) begin
            iMEM_VALID = 1'b1;
            iMEM_DATA  = 64'(j + 100);
            #1;
            chk("t3_get_mreq", 64'(oMEM_REQ), 64'(0));
            chk("t3_get_ivalid", 64'(oINST_VALID), 64'(1));
            step();
        end
        iMEM_VALID = 1'b0;
        #1;
        chk("t3_nreq", 64'(nreq), 64'(8));
        chk("t3_idle", 64'(oINST_LOCK), 64'(0));
        step();

        // Pagefault on the third response with five requests outstanding
        iDATA_REQ    = 1'b1;
        iDATA_ADDR   = 32'h0000_8000;
        iDATA_MMUMOD = 2'd1;
        step();
        iDATA_REQ = 1'b0;
        nreq = 0;
        for (int i = 0; i < 9; i++) begin
            iMEM_LOCK      = (i == 5);
            iMEM_VALID     = (i >= 3 && i <= 7);
            iMEM_PAGEFAULT = (i == 5);
            iMEM_DATA      = 64'(i);
            #1;
            if (oMEM_REQ) nreq++;
            chk("t4_dvalid", 64'(oDATA_VALID), 64'(i >= 3 && i <= 5));
            chk("t4_ivalid", 64'(oINST_VALID), 64'(0));
            if (i == 5) chk("t4_pf", 64'(oRD_PAGEFAULT), 64'(1));
            if (i >= 6) chk("t4_drain_mreq", 64'(oMEM_REQ), 64'(0));
            chk("t4_dlock", 64'(oDATA_LOCK), 64'(1));
            step();
        end
        iMEM_VALID     = 1'b0;
        iMEM_PAGEFAULT = 1'b0;
        #1;
        chk("t4_nreq", 64'(nreq), 64'(5));
        chk("t4_idle", 64'(oDATA_LOCK), 64'(0));
        step();

        // Reset mid-burst, then an immediate DATA request
        iINST_REQ    = 1'b1;
        iINST_ADDR   = 32'h0000_C000;
        iINST_MMUMOD = 2'd2;
        step();
        iINST_REQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t5_mreq", 64'(oMEM_REQ), 64'(1));
            step();
        end
        iMEM_LOCK    = 1'b1;
        iRESET_SYNC  = 1'b1;
        iDATA_REQ    = 1'b1;
        iDATA_ADDR   = 32'h0000_E07F;
        iDATA_MMUMOD = 2'd1;
        #1;
        chk("t5_busy_dlock", 64'(oDATA_LOCK), 64'(1));
        step();
        iRESET_SYNC = 1'b0;
        iMEM_LOCK   = 1'b0;
        #1;
        chk("t5_rst_mreq", 64'(oMEM_REQ), 64'(0));
        chk("t5_rst_dlock", 64'(oDATA_LOCK), 64'(0));
        chk("t5_rst_ilock", 64'(oINST_LOCK), 64'(1));
        step();
        iDATA_REQ = 1'b0;
        burst(1'b1, 32'h0000_E07F, 2'd1);
        #1;
        chk("t5_end_idle", 64'(oDATA_LOCK), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_refill_arbiter.md
L1_REFILL_ARBITER -- requirements
Module: l1_refill_arbiter

Interface
REQ-001 Parameter P_BEATS, default 8, SHALL set the 64-bit beats per 64-byte line refill burst; the only supported value is 8.
REQ-002 iCLOCK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 iRESET_SYNC  in  1  SHALL be the reset; synchronous, active-high.
REQ-004 iINST_REQ  in  1  SHALL be the instruction-cache refill request, held until accepted.
REQ-005 oINST_LOCK  out  1  SHALL signal that the instruction request is not accepted this cycle.
REQ-006 iINST_MMUMOD  in  2  SHALL be the instruction MMU mode, sampled on accept.
REQ-007 iINST_ADDR  in  32  SHALL be the instruction line address; [5:0] ignored; sampled on accept.
REQ-008 oINST_VALID  out  1  SHALL strobe a response beat for the instruction requester.
REQ-009 iDATA_REQ / oDATA_LOCK / iDATA_MMUMOD / iDATA_ADDR / oDATA_VALID  in/out/in/in/out  1/1/2/32/1  SHALL mirror REQ-004..008 for the data-cache requester.
REQ-010 oRD_PAGEFAULT  out  1  SHALL be the pagefault flag of the current response beat.
REQ-011 oRD_DATA  out  64  SHALL be the response beat data, shared by both requesters.
REQ-012 oRD_MMU_FLAGS  out  28  SHALL be the response beat MMU flags, shared by both requesters.
REQ-013 oMEM_REQ / iMEM_LOCK / oMEM_MMUMOD / oMEM_ADDR  out/in/out/out  1/1/2/32  SHALL be the memory request port.
REQ-014 iMEM_VALID / iMEM_PAGEFAULT / iMEM_DATA / iMEM_MMU_FLAGS  in/in/in/in  1/1/64/28  SHALL be the memory response port; responses return in order, no earlier than one cycle after their request.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, GET, DRAIN, plus a 1-bit owner register (0 = INST, 1 = DATA).
REQ-016 In IDLE, a request with its LOCK low SHALL be accepted: latch owner, address[31:6], MMUMOD; clear issued and received counters (4 bits each); next state REQ.
REQ-017 LOCK for a channel SHALL be 1 when the state is not IDLE, or when the other channel wins the same-cycle arbitration.
REQ-018 In REQ, oMEM_REQ SHALL equal !iMEM_LOCK; oMEM_ADDR = {line[31:6], issued[2:0], 3'b000}; oMEM_MMUMOD = latched mode; issued increments per accepted beat.
REQ-019 After the 8th accepted beat (issued = 7 with iMEM_LOCK low), the FSM SHALL go to GET; oMEM_REQ SHALL be 0 in every other state.
REQ-020 In REQ and GET, each iMEM_VALID SHALL increment received and pulse the owner's VALID with oRD_* = iMEM_* in the same cycle (combinational pass-through); the other channel's VALID stays 0.
REQ-021 When received reaches 8 without a pagefault, the FSM SHALL return to IDLE on the following edge.
REQ-022 On iMEM_VALID with iMEM_PAGEFAULT: forward that beat with oRD_PAGEFAULT = 1, stop issuing, go to DRAIN.
REQ-023 In DRAIN, remaining responses SHALL be counted and discarded (no VALID); return to IDLE once received equals issued, including the case where they are already equal.
REQ-024 iMEM_VALID in IDLE SHALL be ignored.
REQ-025 VALID outputs SHALL never be gated by LOCK; requesters must accept every beat of their own burst.

Reset
REQ-026 While iRESET_SYNC = 1 at an edge, the block SHALL enter IDLE with counters, address and mode at 0; the round-robin pointer SHALL be set to favour INST; any burst in flight is abandoned.
REQ-027 Outputs after reset SHALL be: oMEM_REQ = 0, both VALIDs = 0, oRD_* = iMEM_* pass-through, LOCKs per REQ-017.

Configuration
REQ-028 With REFILL_ARB_ROUND_ROBIN_EN defined, a simultaneous request SHALL be granted to the channel that did not own the last completed or aborted burst.
REQ-029 Without REFILL_ARB_ROUND_ROBIN_EN, INST SHALL always win a simultaneous request (fixed priority), and no pointer register is implemented.

Verification
REQ-030 INST request at addr 0x0000_1234, memory never locked -> oMEM_ADDR sequence 0x1200, 0x1208 … 0x1238; 8 oINST_VALID pulses; IDLE one cycle after the 8th.
REQ-031 INST and DATA asserted in the same cycle, twice back-to-back -> without the macro INST wins both; with the macro INST then DATA.
REQ-032 iMEM_LOCK high for 3 cycles during beat 2 -> oMEM_ADDR held at line+0x10 with oMEM_REQ = 0, then resumes; still exactly 8 requests.
REQ-033 Pagefault on response 3 with 5 requests issued -> oRD_PAGEFAULT pulse with VALID, 2 further responses swallowed, IDLE afterwards, 5 requests total.
REQ-034 iRESET_SYNC asserted after 4 issued beats -> IDLE next edge; oMEM_REQ = 0; new DATA request accepted immediately.
